// File: rtl/apple_spawner.sv
// Picks a free playfield cell for a new apple: random LFSR probes against the snake
// occupancy map, then a linear scan of all 64 cells if every probe hit the snake.
module apple_spawner #(
  parameter int unsigned MAX_TRIES = 32,
  parameter logic [7:0]  LFSR_SEED = 8'hB4,
  parameter logic [2:0]  INIT_ROW  = 3'd3,
  parameter logic [2:0]  INIT_COL  = 3'd6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spawn_req,
  input  logic [63:0] occupancy,
  input  logic        seed_load,
  input  logic [7:0]  seed,
  output logic [2:0]  apple_row,
  output logic [2:0]  apple_col,
  output logic        busy,
  output logic        done,
  output logic        fail
);

  typedef enum logic [1:0] {StIdle, StProbe, StScan} state_e;

  localparam logic [7:0] LastTry = 8'(MAX_TRIES - 1);

  state_e      state_q, state_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [7:0]  tries_q, tries_d;
  logic [5:0]  scan_idx_q, scan_idx_d;
  logic [2:0]  row_q, row_d;
  logic [2:0]  col_q, col_d;
  logic        done_q, done_d;
  logic        fail_q, fail_d;
  logic        fb;
  logic [7:0]  lfsr_step;

  always_comb begin
    fb        = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    lfsr_step = {lfsr_q[6:0], fb};
  end

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_step;
    tries_d    = tries_q;
    scan_idx_d = scan_idx_q;
    row_d      = row_q;
    col_d      = col_q;
    done_d     = 1'b0;
    fail_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A seed load freezes the LFSR for this edge and swallows any request.
        if (seed_load) begin
          lfsr_d = (seed == 8'h00) ? LFSR_SEED : seed;
        end else if (spawn_req) begin
          tries_d = 8'd0;
          state_d = StProbe;
        end
      end
      StProbe: begin
        if (!occupancy[lfsr_q[5:0]]) begin
          row_d   = lfsr_q[5:3];
          col_d   = lfsr_q[2:0];
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (tries_q == LastTry) begin
          scan_idx_d = 6'd0;
          state_d    = StScan;
        end else begin
          tries_d = tries_q + 8'd1;
        end
      end
      StScan: begin
        if (!occupancy[scan_idx_q]) begin
          row_d   = scan_idx_q[5:3];
          col_d   = scan_idx_q[2:0];
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (scan_idx_q == 6'd63) begin
          fail_d  = 1'b1;
          state_d = StIdle;
        end else begin
          scan_idx_d = scan_idx_q + 6'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      lfsr_q     <= LFSR_SEED;
      tries_q    <= 8'd0;
      scan_idx_q <= 6'd0;
      row_q      <= INIT_ROW;
      col_q      <= INIT_COL;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      tries_q    <= tries_d;
      scan_idx_q <= scan_idx_d;
      row_q      <= row_d;
      col_q      <= col_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
    end
  end

  assign apple_row = row_q;
  assign apple_col = col_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign fail      = fail_q;

endmodule

// File: tb/tb_apple_spawner.sv
// Self-checking bench for apple_spawner: directed scenarios plus randomized traffic,
// all compared every cycle against an outcome-level reference model.
module tb_apple_spawner;

  localparam int unsigned MT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spawn_req = 1'b0;
  logic [63:0] occupancy = 64'h0;
  logic        seed_load = 1'b0;
  logic [7:0]  seed = 8'h00;
  logic [2:0]  apple_row, apple_col;
  logic        busy, done, fail;

  int n_assert = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  apple_spawner #(
    .MAX_TRIES(MT),
    .LFSR_SEED(8'hB4),
    .INIT_ROW (3'd3),
    .INIT_COL (3'd6)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .spawn_req(spawn_req),
    .occupancy(occupancy),
    .seed_load(seed_load),
    .seed     (seed),
    .apple_row(apple_row),
    .apple_col(apple_col),
    .busy     (busy),
    .done     (done),
    .fail     (fail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        ok;
    logic [2:0]  row;
    logic [2:0]  col;
    logic [15:0] rem;   // edges from the request edge until the done/fail edge
  } plan_t;

  function automatic logic [7:0] step(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  // Whole outcome of a request decided up front from the LFSR sequence and the map.
  function automatic plan_t plan(input logic [7:0] first, input logic [63:0] occ);
    plan_t       p;
    logic [7:0]  v;
    bit          found;
    p     = '0;
    v     = first;
    found = 1'b0;
    for (int k = 0; k < int'(MT); k++) begin
      if (!found && !occ[v[5:0]]) begin
        found = 1'b1;
        p.ok  = 1'b1;
        p.row = v[5:3];
        p.col = v[2:0];
        p.rem = 16'(k + 1);
      end
      v = step(v);
    end
    for (int j = 0; j < 64; j++) begin
      if (!found && !occ[j]) begin
        found = 1'b1;
        p.ok  = 1'b1;
        p.row = 3'(j / 8);
        p.col = 3'(j % 8);
        p.rem = 16'(int'(MT) + 1 + j);
      end
    end
    if (!found) begin
      p.ok  = 1'b0;
      p.rem = 16'(int'(MT) + 64);
    end
    return p;
  endfunction

  logic [7:0]  m_lfsr;
  logic        m_busy, m_done, m_fail;
  logic [2:0]  m_row, m_col;
  plan_t       m_plan;
  plan_t       p_now;

  assign p_now = plan(step(m_lfsr), occupancy);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_lfsr <= 8'hB4;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_fail <= 1'b0;
      m_row  <= 3'd3;
      m_col  <= 3'd6;
      m_plan <= '0;
    end else begin
      m_done <= 1'b0;
      m_fail <= 1'b0;
      if (!m_busy) begin
        if (seed_load) begin
          m_lfsr <= (seed == 8'h00) ? 8'hB4 : seed;
        end else begin
          m_lfsr <= step(m_lfsr);
          if (spawn_req) begin
            m_plan <= p_now;
            m_busy <= 1'b1;
          end
        end
      end else begin
        m_lfsr     <= step(m_lfsr);
        m_plan.rem <= m_plan.rem - 16'd1;
        if (m_plan.rem == 16'd1) begin
          m_busy <= 1'b0;
          if (m_plan.ok) begin
            m_done <= 1'b1;
            m_row  <= m_plan.row;
            m_col  <= m_plan.col;
          end else begin
            m_fail <= 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      chk("busy", int'(busy), int'(m_busy));
      chk("done", int'(done), int'(m_done));
      chk("fail", int'(fail), int'(m_fail));
      chk("apple_row", int'(apple_row), int'(m_row));
      chk("apple_col", int'(apple_col), int'(m_col));
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [63:0] gen_occ(input int kind);
    case (kind)
      0:       return 64'h0;
      1:       return {$urandom(), $urandom()};
      2:       return {$urandom(), $urandom()} | {$urandom(), $urandom()} |
                      {$urandom(), $urandom()} | {$urandom(), $urandom()};
      3:       return ~(64'h1 << $urandom_range(63));
      default: return '1;
    endcase
  endfunction

  task automatic pulse_reset_midcycle();
    @(posedge clk);
    #2 reset = 1'b1;
    #2 reset = 1'b0;
  endtask

  initial begin
    int n;
    int n_done;
    int n_fail_seen;
    bit seen;

    repeat (3) @(negedge clk);
    chk("reset_row", int'(apple_row), 3);
    chk("reset_col", int'(apple_col), 6);
    chk("reset_busy", int'(busy), 0);
    reset  = 1'b0;
    cmp_en = 1'b1;

    // Seeded spawn: 0x2A -> 0x54 -> apple (2,4) two edges after the request.
    seed = 8'h2A; seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0; spawn_req = 1'b1;
    @(negedge clk);
    spawn_req = 1'b0;
    chk("seeded_busy_after_req", int'(busy), 1);
    chk("seeded_no_early_done", int'(done), 0);
    @(negedge clk);
    chk("seeded_done", int'(done), 1);
    chk("seeded_row", int'(apple_row), 2);
    chk("seeded_col", int'(apple_col), 4);
    chk("seeded_busy_clear", int'(busy), 0);
    @(negedge clk);
    chk("seeded_done_one_cycle", int'(done), 0);

    // Asynchronous reset with no clock edge.
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_row", int'(apple_row), 3);
    chk("async_reset_col", int'(apple_col), 6);
    chk("async_reset_busy", int'(busy), 0);
    chk("async_reset_done", int'(done), 0);
    @(negedge clk);
    reset = 1'b0;

    // Zero seed falls back to 0xB4 -> next 0x69 -> apple (5,1).
    seed = 8'h00; seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0; spawn_req = 1'b1;
    @(negedge clk);
    spawn_req = 1'b0;
    @(negedge clk);
    chk("zero_seed_done", int'(done), 1);
    chk("zero_seed_row", int'(apple_row), 5);
    chk("zero_seed_col", int'(apple_col), 1);

    // seed_load wins over a simultaneous request.
    seed = 8'h11; seed_load = 1'b1; spawn_req = 1'b1;
    @(negedge clk);
    seed_load = 1'b0; spawn_req = 1'b0;
    chk("seed_wins_busy", int'(busy), 0);
    @(negedge clk);
    chk("seed_wins_still_idle", int'(busy), 0);

    // Only bit 63 free: done with (7,7) within MT+64 edges, never fail.
    occupancy = 64'h7FFF_FFFF_FFFF_FFFF;
    spawn_req = 1'b1;
    @(negedge clk);
    spawn_req = 1'b0;
    n = 0; seen = 1'b0; n_fail_seen = 0;
    while (!seen && n < int'(MT) + 70) begin
      @(negedge clk);
      n++;
      if (fail) n_fail_seen++;
      if (done) seen = 1'b1;
    end
    chk("fallback_done_seen", int'(seen), 1);
    chk("fallback_latency_ok", int'(n <= int'(MT) + 64), 1);
    chk("fallback_row", int'(apple_row), 7);
    chk("fallback_col", int'(apple_col), 7);
    chk("fallback_no_fail", n_fail_seen, 0);

    // Full board: fail exactly MT+64 edges after the request, apple unchanged.
    occupancy = '1;
    spawn_req = 1'b1;
    @(negedge clk);
    spawn_req = 1'b0;
    n = 0; seen = 1'b0; n_done = 0;
    while (!seen && n < int'(MT) + 70) begin
      @(negedge clk);
      n++;
      if (done) n_done++;
      if (fail) seen = 1'b1;
    end
    chk("full_fail_seen", int'(seen), 1);
    chk("full_fail_latency", n, int'(MT) + 64);
    chk("full_no_done", n_done, 0);
    chk("full_row_kept", int'(apple_row), 7);
    chk("full_col_kept", int'(apple_col), 7);
    @(negedge clk);
    chk("full_fail_one_cycle", int'(fail), 0);

    // Request held high through the busy period: exactly one done.
    occupancy = ~(64'h1 << 40);
    spawn_req = 1'b1;
    n = 0; n_done = 0;
    while (n_done == 0 && n < 200) begin
      @(negedge clk);
      n++;
      if (done) begin
        n_done++;
        spawn_req = 1'b0;
      end
    end
    repeat (3) begin
      @(negedge clk);
      if (done) n_done++;
    end
    spawn_req = 1'b0;
    chk("held_req_one_done", n_done, 1);
    chk("held_req_idle", int'(busy), 0);

    // Reset ten cycles into SCAN aborts without a pulse.
    occupancy = '1;
    spawn_req = 1'b1;
    @(negedge clk);
    spawn_req = 1'b0;
    n_done = 0; n_fail_seen = 0;
    repeat (int'(MT) + 10) begin
      @(negedge clk);
      if (done) n_done++;
      if (fail) n_fail_seen++;
    end
    chk("scan_busy_before_reset", int'(busy), 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("scan_reset_busy", int'(busy), 0);
    chk("scan_reset_row", int'(apple_row), 3);
    chk("scan_reset_col", int'(apple_col), 6);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done) n_done++;
      if (fail) n_fail_seen++;
    end
    chk("scan_reset_no_done", n_done, 0);
    chk("scan_reset_no_fail", n_fail_seen, 0);
    occupancy = 64'h0;
    spawn_req = 1'b1;
    @(negedge clk);
    spawn_req = 1'b0;
    @(negedge clk);
    chk("after_reset_spawn_done", int'(done), 1);

    // Randomized traffic; occupancy only changes while idle.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(299) == 0) begin
        pulse_reset_midcycle();
        @(negedge clk);
      end
      if (!m_busy) occupancy = gen_occ($urandom_range(4));
      spawn_req = ($urandom_range(2) == 0);
      seed_load = ($urandom_range(9) == 0);
      seed      = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom());
    end
    spawn_req = 1'b0;
    seed_load = 1'b0;
    n = 0;
    while (m_busy && n < int'(MT) + 70) begin
      @(negedge clk);
      n++;
    end
    chk("random_drain", int'(m_busy), 0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
